// File: rtl/sdram_pro_read_pkg.sv
// ----------------------------------------------------------------------------
// sdram_pro_read_pkg
//   Shared definitions for the SDRAM read engine.
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}.
//   - Address value that makes PRECHARGE close all banks (A10 = 1).
//   - Read-engine FSM state type.
// ----------------------------------------------------------------------------
package sdram_pro_read_pkg;

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE = 4'b0011;
  localparam logic [3:0] CMD_READ   = 4'b0101;
  localparam logic [3:0] CMD_BSTOP  = 4'b0110;
  localparam logic [3:0] CMD_PRECH  = 4'b0010;

  localparam logic [11:0] ADDR_PRECH_ALL = 12'h400;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT,
    S_WAIT_RCD,
    S_RD,
    S_RD_DATA,
    S_WAIT_CL,
    S_PRECH,
    S_WAIT_RP,
    S_END
  } rd_state_e;

endpackage

// File: rtl/sdram_pro_read_if.sv
// ----------------------------------------------------------------------------
// sdram_pro_read_if
//   Bundles the read engine's user, arbiter and SDRAM-side signals.
//   slave  : the read engine (drives rd_req/rd_end/command bus/captured data)
//   master : the surroundings (user trigger, arbiter grant, SDRAM DQ)
//   Signals:
//     init_end       SDRAM init done
//     rd_trig        user read strobe
//     rd_start_addr  {bank[22:21], row[20:9], col[8:0]}
//     rd_burst_len   requested words (0 -> 1, clamped to the maximum burst)
//     rd_en          registered arbiter read grant
//     sdram_data_in  SDRAM DQ input
//     rd_req         request to arbiter
//     rd_end         one-clock completion pulse
//     rd_cmd         {cs_n,ras_n,cas_n,we_n}
//     rd_bank        bank address
//     rd_addr        address bus
//     rd_data        captured read word
//     rd_data_valid  rd_data is valid this clock
//     rd_busy        request pending or in progress
// ----------------------------------------------------------------------------
interface sdram_pro_read_if;

  logic        init_end;
  logic        rd_trig;
  logic [22:0] rd_start_addr;
  logic [8:0]  rd_burst_len;
  logic        rd_en;
  logic [15:0] sdram_data_in;
  logic        rd_req;
  logic        rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_bank;
  logic [11:0] rd_addr;
  logic [15:0] rd_data;
  logic        rd_data_valid;
  logic        rd_busy;

  modport slave (
    input  init_end, rd_trig, rd_start_addr, rd_burst_len, rd_en, sdram_data_in,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr, rd_data, rd_data_valid, rd_busy
  );

  modport master (
    output init_end, rd_trig, rd_start_addr, rd_burst_len, rd_en, sdram_data_in,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr, rd_data, rd_data_valid, rd_busy
  );

endinterface

// File: rtl/sdram_pro_read.sv
// ----------------------------------------------------------------------------
// sdram_pro_read
//   SDRAM read engine. Latches one user read (start address, burst length),
//   requests the arbiter, and once granted issues ACTIVE, READ, BURST_STOP and
//   PRECHARGE, captures the returned words and pulses rd_end.
//   Ports:
//     sys_clk    system clock, all logic on posedge
//     sys_rst_n  synchronous active-low reset
//     bus        sdram_pro_read_if.slave (user / arbiter / SDRAM signals)
//   All outputs are registered.
// ----------------------------------------------------------------------------
module sdram_pro_read
  import sdram_pro_read_pkg::*;
#(
  parameter int CAS_LAT   = 3,
  parameter int TRCD      = 2,
  parameter int TRP       = 2,
  parameter int MAX_BURST = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  sdram_pro_read_if.slave   bus
);

  rd_state_e    r_state, w_state_nxt;
  logic [8:0]   r_cnt, w_cnt_nxt;
  logic [3:0]   r_cmd, w_cmd_nxt;
  logic [1:0]   r_bank, w_bank_nxt;
  logic [11:0]  r_rd_addr, w_addr_nxt;
  logic [22:0]  r_start_addr;
  logic [8:0]   r_len;
  logic         r_busy, r_req, r_end, r_armed;
  logic         w_accept, w_busy_nxt, w_enter_end;
  logic [CAS_LAT:0] r_rd_pipe;
  logic [8:0]   r_wcnt;
  logic         r_vld_p1;
  logic [15:0]  r_data_p1;

  // Zero-length requests read one word; oversize requests saturate so a
  // single grant cannot block auto-refresh for too long.
  function automatic logic [8:0] clamp_len(input logic [8:0] len);
    if (len == 9'd0)
      return 9'd1;
    if (int'(len) > MAX_BURST)
      return 9'(MAX_BURST);
    return len;
  endfunction

  // The rd_end clock has rd_busy=0 but must not take a new request.
  assign w_accept    = bus.rd_trig && !r_busy && (r_state != S_END);
  assign w_enter_end = (w_state_nxt == S_END);
  assign w_busy_nxt  = w_enter_end ? 1'b0 : (w_accept ? 1'b1 : r_busy);

  // Next state and the command registered for the coming clock. r_cnt is
  // shared by all wait states and by the READ-to-BURST_STOP spacing.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cmd_nxt   = CMD_NOP;
    w_bank_nxt  = 2'd0;
    w_addr_nxt  = 12'd0;
    case (r_state)
      S_IDLE: begin
        if (r_busy && bus.rd_en && r_armed) begin
          w_state_nxt = S_ACT;
          w_cmd_nxt   = CMD_ACTIVE;
          w_bank_nxt  = r_start_addr[22:21];
          w_addr_nxt  = r_start_addr[20:9];
        end
      end
      S_ACT: begin
        if (TRCD == 1) begin
          w_state_nxt = S_RD;
          w_cmd_nxt   = CMD_READ;
          w_addr_nxt  = {3'b000, r_start_addr[8:0]};
        end else begin
          w_state_nxt = S_WAIT_RCD;
          w_cnt_nxt   = 9'(TRCD - 2);
        end
      end
      S_WAIT_RCD: begin
        if (r_cnt == 9'd0) begin
          w_state_nxt = S_RD;
          w_cmd_nxt   = CMD_READ;
          w_addr_nxt  = {3'b000, r_start_addr[8:0]};
        end else begin
          w_cnt_nxt = r_cnt - 9'd1;
        end
      end
      S_RD: begin
        // RD_DATA lasts N clocks; its last clock carries BURST_STOP.
        w_state_nxt = S_RD_DATA;
        w_cnt_nxt   = r_len - 9'd1;
        if (r_len == 9'd1)
          w_cmd_nxt = CMD_BSTOP;
      end
      S_RD_DATA: begin
        if (r_cnt == 9'd0) begin
          w_state_nxt = S_WAIT_CL;
          w_cnt_nxt   = 9'(CAS_LAT - 2);
        end else begin
          w_cnt_nxt = r_cnt - 9'd1;
          if (r_cnt == 9'd1)
            w_cmd_nxt = CMD_BSTOP;
        end
      end
      S_WAIT_CL: begin
        if (r_cnt == 9'd0) begin
          w_state_nxt = S_PRECH;
          w_cmd_nxt   = CMD_PRECH;
          w_addr_nxt  = ADDR_PRECH_ALL;
        end else begin
          w_cnt_nxt = r_cnt - 9'd1;
        end
      end
      S_PRECH: begin
        if (TRP == 1) begin
          w_state_nxt = S_END;
        end else begin
          w_state_nxt = S_WAIT_RP;
          w_cnt_nxt   = 9'(TRP - 2);
        end
      end
      S_WAIT_RP: begin
        if (r_cnt == 9'd0)
          w_state_nxt = S_END;
        else
          w_cnt_nxt = r_cnt - 9'd1;
      end
      S_END:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch: only loaded on acceptance, no reset needed.
  always_ff @(posedge sys_clk) begin
    if (w_accept) begin
      r_start_addr <= bus.rd_start_addr;
      r_len        <= clamp_len(bus.rd_burst_len);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 9'd0;
      r_cmd     <= CMD_NOP;
      r_bank    <= 2'd0;
      r_rd_addr <= 12'd0;
      r_busy    <= 1'b0;
      r_req     <= 1'b0;
      r_end     <= 1'b0;
      r_armed   <= 1'b0;
      r_rd_pipe <= '0;
      r_wcnt    <= 9'd0;
      r_vld_p1  <= 1'b0;
      r_data_p1 <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cmd     <= w_cmd_nxt;
      r_bank    <= w_bank_nxt;
      r_rd_addr <= w_addr_nxt;
      r_busy    <= w_busy_nxt;
      r_req     <= w_busy_nxt && bus.init_end;
      r_end     <= w_enter_end;
      // Re-arm only after the grant has been seen low, so a grant still
      // high just after rd_end cannot start the next request.
      if (w_enter_end)
        r_armed <= 1'b0;
      else if (!bus.rd_en)
        r_armed <= 1'b1;
      // r_rd_pipe[CAS_LAT] is high on the clock the first word is on DQ.
      r_rd_pipe <= {r_rd_pipe[CAS_LAT-1:0], (w_state_nxt == S_RD)};

      // ---- capture stage p1: DQ registered once ----
      r_data_p1 <= bus.sdram_data_in;
      if (r_rd_pipe[CAS_LAT]) begin
        r_vld_p1 <= 1'b1;
        r_wcnt   <= r_len - 9'd1;
      end else if (r_wcnt != 9'd0) begin
        r_vld_p1 <= 1'b1;
        r_wcnt   <= r_wcnt - 9'd1;
      end else begin
        r_vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.rd_req        = r_req;
  assign bus.rd_end        = r_end;
  assign bus.rd_cmd        = r_cmd;
  assign bus.rd_bank       = r_bank;
  assign bus.rd_addr       = r_rd_addr;
  assign bus.rd_data       = r_data_p1;
  assign bus.rd_data_valid = r_vld_p1;
  assign bus.rd_busy       = r_busy;

endmodule

// File: tb/tb_sdram_pro_read.sv
// ----------------------------------------------------------------------------
// tb_sdram_pro_read
//   Bench for sdram_pro_read (CAS_LAT=3, TRCD=2, TRP=2, MAX_BURST=256).
//   A schedule-based model predicts every output for every clock from the
//   grant clock e: ACTIVE e+1, READ t=e+1+TRCD, BSTOP t+N, PRECH t+N+CL,
//   rd_end t+N+CL+TRP, valid t+CL+1..t+CL+N. Directed scenarios add literal
//   expectations on observed event clocks.
// ----------------------------------------------------------------------------
module tb_sdram_pro_read;
  import sdram_pro_read_pkg::*;

  localparam int CL   = 3;
  localparam int TRCD = 2;
  localparam int TRP  = 2;
  localparam int MAXB = 256;

  logic clk = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_pro_read_if bus();

  sdram_pro_read #(.CAS_LAT(CL), .TRCD(TRCD), .TRP(TRP), .MAX_BURST(MAXB)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model state
  bit          m_known, m_pend, m_armed, m_run;
  logic [22:0] m_addr;
  int          m_n, m_e, m_t, m_endc;
  logic [3:0]  x_cmd;
  logic [1:0]  x_bank;
  logic [11:0] x_addr;
  logic        x_req, x_end, x_valid, x_busy;
  logic [15:0] x_data;

  // observed event clocks of the most recent sequence
  int          obs_act, obs_rd, obs_bst, obs_pre, obs_end, obs_vfirst, obs_vlast, obs_vcnt;
  logic [1:0]  obs_bank;
  logic [11:0] obs_act_addr, obs_rd_addr, obs_pre_addr;
  logic        obs_req_end;

  function automatic int clamp(input logic [8:0] len);
    if (len == 9'd0) return 1;
    if (int'(len) > MAXB) return MAXB;
    return int'(len);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Runs on the falling edge of clock cyc: compare, observe, then predict cyc+1.
  task automatic model_check();
    int k;
    bit was_run, in_end, accept;
    if (m_known) begin
      chk("rd_cmd",   32'(bus.rd_cmd),        32'(x_cmd));
      chk("rd_bank",  32'(bus.rd_bank),       32'(x_bank));
      chk("rd_addr",  32'(bus.rd_addr),       32'(x_addr));
      chk("rd_req",   32'(bus.rd_req),        32'(x_req));
      chk("rd_end",   32'(bus.rd_end),        32'(x_end));
      chk("rd_busy",  32'(bus.rd_busy),       32'(x_busy));
      chk("rd_valid", 32'(bus.rd_data_valid), 32'(x_valid));
      if (x_valid) chk("rd_data", 32'(bus.rd_data), 32'(x_data));
    end
    if (bus.rd_cmd == CMD_ACTIVE) begin
      obs_act = cyc; obs_bank = bus.rd_bank; obs_act_addr = bus.rd_addr; obs_vcnt = 0;
    end
    if (bus.rd_cmd == CMD_READ)  begin obs_rd = cyc; obs_rd_addr = bus.rd_addr; end
    if (bus.rd_cmd == CMD_BSTOP) obs_bst = cyc;
    if (bus.rd_cmd == CMD_PRECH) begin obs_pre = cyc; obs_pre_addr = bus.rd_addr; end
    if (bus.rd_data_valid) begin
      if (obs_vcnt == 0) obs_vfirst = cyc;
      obs_vlast = cyc; obs_vcnt++;
    end
    if (bus.rd_end) begin obs_end = cyc; obs_req_end = bus.rd_req; end

    k = cyc + 1;
    if (!rst_n) begin
      m_known = 1; m_pend = 0; m_armed = 0; m_run = 0;
      x_cmd = CMD_NOP; x_bank = 0; x_addr = 0;
      x_req = 0; x_end = 0; x_valid = 0; x_busy = 0; x_data = 0;
    end else begin
      was_run = m_run;
      in_end  = m_run && (cyc == m_endc);
      accept  = bus.rd_trig && !m_pend && !in_end;
      if (!was_run && m_pend && bus.rd_en && m_armed) begin
        m_run = 1; m_e = cyc; m_t = cyc + 1 + TRCD; m_endc = m_t + m_n + CL + TRP;
      end else if (in_end) begin
        m_run = 0;
      end
      if (m_run && k == m_endc) m_armed = 0;
      else if (!bus.rd_en)      m_armed = 1;
      if (m_run && k == m_endc) m_pend = 0;
      else if (accept) begin
        m_pend = 1; m_addr = bus.rd_start_addr; m_n = clamp(bus.rd_burst_len);
      end
      x_busy = m_pend;
      x_req  = m_pend && bus.init_end;
      x_cmd = CMD_NOP; x_bank = 0; x_addr = 0;
      if (m_run) begin
        if (k == m_e + 1) begin
          x_cmd = CMD_ACTIVE; x_bank = m_addr[22:21]; x_addr = m_addr[20:9];
        end else if (k == m_t) begin
          x_cmd = CMD_READ; x_addr = {3'b000, m_addr[8:0]};
        end else if (k == m_t + m_n) begin
          x_cmd = CMD_BSTOP;
        end else if (k == m_t + m_n + CL) begin
          x_cmd = CMD_PRECH; x_addr = 12'h400;
        end
      end
      x_end   = m_run && (k == m_endc);
      x_valid = m_run && (k >= m_t + CL + 1) && (k <= m_t + CL + m_n);
      x_data  = bus.sdram_data_in;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
    bus.sdram_data_in = 16'($urandom);
  endtask

  task automatic trig(input logic [22:0] a, input logic [8:0] len);
    bus.rd_trig = 1; bus.rd_start_addr = a; bus.rd_burst_len = len;
    step();
    bus.rd_trig = 0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!bus.rd_req && n < 50) begin step(); n++; end
    chk("rd_req_seen", 32'(bus.rd_req), 32'd1);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!bus.rd_end && n < 2000) begin step(); n++; end
    chk("rd_end_seen", 32'(bus.rd_end), 32'd1);
  endtask

  // Arbiter grant: rd_en after dly clocks, optional early drop, held hold
  // clocks past rd_end; rt adds random user strobes while the grant runs.
  task automatic grant(input int dly, input int hold, input int drop_at, input bit rt, output int e);
    int n;
    repeat (dly) step();
    bus.rd_en = 1; e = cyc; n = 0;
    while (!bus.rd_end && n < 2000) begin
      step(); n++;
      if (drop_at > 0 && n == drop_at) bus.rd_en = 0;
      bus.rd_trig = rt && ($urandom_range(0, 7) == 0);
      bus.rd_start_addr = 23'($urandom);
      bus.rd_burst_len  = 9'($urandom);
    end
    chk("rd_end_seen", 32'(bus.rd_end), 32'd1);
    bus.rd_trig = 0;
    repeat (hold) step();
    bus.rd_en = 0;
  endtask

  initial begin
    int e, e2, prev, prev_pre, prev_end;
    rst_n = 0;
    bus.init_end = 1; bus.rd_trig = 0; bus.rd_start_addr = 0; bus.rd_burst_len = 0;
    bus.rd_en = 0; bus.sdram_data_in = 0;
    obs_act = -1; obs_pre = -1; obs_end = -1; obs_vcnt = 0;
    repeat (3) step();
    chk("reset_cmd",  32'(bus.rd_cmd),  32'h7);
    chk("reset_busy", 32'(bus.rd_busy), 32'd0);
    chk("reset_req",  32'(bus.rd_req),  32'd0);
    rst_n = 1;
    repeat (2) step();

    // 1: basic timing
    trig({2'b01, 12'h0A5, 9'h010}, 9'd4);
    wait_req();
    grant(0, 0, 0, 0, e);
    step();
    chk("t1_act",      32'(obs_act),      32'(e + 1));
    chk("t1_bank",     32'(obs_bank),     32'd1);
    chk("t1_act_addr", 32'(obs_act_addr), 32'h0A5);
    chk("t1_read",     32'(obs_rd),       32'(e + 3));
    chk("t1_rd_addr",  32'(obs_rd_addr),  32'h010);
    chk("t1_bstop",    32'(obs_bst),      32'(e + 7));
    chk("t1_vfirst",   32'(obs_vfirst),   32'(e + 7));
    chk("t1_vlast",    32'(obs_vlast),    32'(e + 10));
    chk("t1_vcnt",     32'(obs_vcnt),     32'd4);
    chk("t1_prech",    32'(obs_pre),      32'(e + 10));
    chk("t1_pre_addr", 32'(obs_pre_addr), 32'h400);
    chk("t1_end",      32'(obs_end),      32'(e + 12));
    chk("t1_req_end",  32'(obs_req_end),  32'd0);

    // 2: length 0 and oversize length
    trig({2'b10, 12'h001, 9'h1FF}, 9'd0);
    wait_req(); grant(1, 0, 0, 0, e); step();
    chk("t2_len0_vcnt", 32'(obs_vcnt), 32'd1);
    trig({2'b11, 12'hABC, 9'h100}, 9'd300);
    wait_req(); grant(0, 0, 0, 0, e); step();
    chk("t2_len300_vcnt", 32'(obs_vcnt), 32'd256);
    chk("t2_bstop_gap",   32'(obs_bst - obs_rd), 32'd256);
    chk("t2_end_gap",     32'(obs_end - obs_rd), 32'(256 + CL + TRP));

    // 3: grant still high after rd_end with a new request pending
    trig({2'b00, 12'h011, 9'h000}, 9'd2);
    wait_req();
    bus.rd_en = 1;
    wait_end();
    step();
    bus.rd_trig = 1; bus.rd_start_addr = {2'b10, 12'h155, 9'h005}; bus.rd_burst_len = 9'd1;
    step();
    bus.rd_trig = 0;
    prev = obs_act;
    repeat (4) step();
    chk("t3_no_restart", 32'(obs_act), 32'(prev));
    bus.rd_en = 0; step();
    bus.rd_en = 1; e2 = cyc;
    wait_end();
    bus.rd_en = 0; step();
    chk("t3_act",      32'(obs_act),      32'(e2 + 1));
    chk("t3_act_addr", 32'(obs_act_addr), 32'h155);

    // 4: trigger while busy is ignored
    trig({2'b01, 12'h123, 9'h020}, 9'd2);
    trig({2'b10, 12'h3FF, 9'h030}, 9'd5);
    wait_req(); grant(0, 0, 0, 0, e); step();
    chk("t4_act_addr", 32'(obs_act_addr), 32'h123);
    chk("t4_vcnt",     32'(obs_vcnt),     32'd2);

    // 5: reset one clock after READ
    trig({2'b00, 12'h222, 9'h000}, 9'd8);
    wait_req();
    bus.rd_en = 1;
    begin
      int n;
      n = 0;
      while (bus.rd_cmd != CMD_READ && n < 20) begin step(); n++; end
    end
    chk("t5_read_seen", 32'(bus.rd_cmd), 32'(CMD_READ));
    step();
    rst_n = 0;
    step();
    chk("t5_cmd",   32'(bus.rd_cmd),        32'h7);
    chk("t5_addr",  32'(bus.rd_addr),       32'd0);
    chk("t5_busy",  32'(bus.rd_busy),       32'd0);
    chk("t5_valid", 32'(bus.rd_data_valid), 32'd0);
    bus.rd_en = 0;
    prev_pre = obs_pre; prev_end = obs_end;
    step();
    rst_n = 1;
    repeat (12) step();
    chk("t5_no_prech", 32'(obs_pre), 32'(prev_pre));
    chk("t5_no_end",   32'(obs_end), 32'(prev_end));

    // 6: init_end low holds off rd_req
    bus.init_end = 0;
    trig({2'b11, 12'h0F0, 9'h0F0}, 9'd3);
    repeat (3) step();
    chk("t6_req_low", 32'(bus.rd_req),  32'd0);
    chk("t6_busy",    32'(bus.rd_busy), 32'd1);
    bus.init_end = 1;
    step();
    chk("t6_req_high", 32'(bus.rd_req), 32'd1);
    grant(0, 0, 0, 0, e); step();

    // random traffic
    for (int i = 0; i < 20; i++) begin
      trig(23'($urandom), 9'($urandom_range(0, 300)));
      wait_req();
      grant($urandom_range(0, 3), $urandom_range(0, 2),
            ($urandom_range(0, 4) == 0) ? $urandom_range(1, 10) : 0, 1'b1, e);
      repeat ($urandom_range(1, 3)) step();
    end
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
